// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with FWFT option, programmable thresholds and timed reset-busy.
// Optional FIFO_ERR_FLAGS_EN macro adds registered overflow/underflow pulse outputs.
module sync_fifo_param #(
  parameter int unsigned WIDTH             = 32,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned FWFT              = 0,
  parameter int unsigned PROG_FULL_THRESH  = 12,
  parameter int unsigned PROG_EMPTY_THRESH = 2,
  parameter int unsigned RST_BUSY_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     prog_full,
  output logic                     prog_empty,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic                     wr_rst_busy,
  output logic                     rd_rst_busy
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(RST_BUSY_CYCLES + 1);

  typedef enum logic [0:0] {
    ST_BUSY = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t           state, state_nxt;
  logic [BW-1:0]    busy_cnt, busy_cnt_nxt;
  logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] dout_nxt;
  logic             wr_acc, rd_acc;
  logic             busy;
`ifdef FIFO_ERR_FLAGS_EN
  logic             overflow_nxt, underflow_nxt;
`endif

  assign busy = (state == ST_BUSY);

  // Next-state: reset-busy sequencing, accepts, pointers, occupancy and next dout.
  always_comb begin
    state_nxt    = state;
    busy_cnt_nxt = busy_cnt;
    wr_acc       = 1'b0;
    rd_acc       = 1'b0;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    dout_nxt     = dout;
`ifdef FIFO_ERR_FLAGS_EN
    overflow_nxt  = 1'b0;
    underflow_nxt = 1'b0;
`endif

    case (state)
      ST_BUSY: begin
        if (busy_cnt <= BW'(1)) begin
          state_nxt    = ST_RUN;
          busy_cnt_nxt = '0;
        end else begin
          busy_cnt_nxt = busy_cnt - BW'(1);
        end
      end
      ST_RUN: ;
      default: state_nxt = ST_BUSY;
    endcase

    wr_acc = wr_en && !full && !busy;
    rd_acc = rd_en && !empty && !busy;

    if (wr_acc) wr_ptr_nxt = wr_ptr + AW'(1);
    if (rd_acc) rd_ptr_nxt = rd_ptr + AW'(1);
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);

    if (FWFT != 0) begin
      // Present the next head; a write landing on it bypasses the array.
      if (wr_acc && (wr_ptr == rd_ptr_nxt)) dout_nxt = din;
      else                                  dout_nxt = mem[rd_ptr_nxt];
    end else if (rd_acc) begin
      dout_nxt = mem[rd_ptr];
    end

`ifdef FIFO_ERR_FLAGS_EN
    overflow_nxt  = wr_en && full && !busy;
    underflow_nxt = rd_en && empty && !busy;
`endif
  end

  // Control and flag registers; every flag derives from next-count on the same edge.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state       <= ST_BUSY;
      busy_cnt    <= BW'(RST_BUSY_CYCLES);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dout        <= '0;
      full        <= 1'b1;
      empty       <= 1'b1;
      prog_full   <= 1'b0;
      prog_empty  <= 1'b1;
      data_count  <= '0;
      wr_rst_busy <= 1'b1;
      rd_rst_busy <= 1'b1;
`ifdef FIFO_ERR_FLAGS_EN
      overflow    <= 1'b0;
      underflow   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      busy_cnt    <= busy_cnt_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      dout        <= dout_nxt;
      full        <= (state_nxt == ST_BUSY) || (count_nxt == CW'(DEPTH));
      empty       <= (count_nxt == '0);
      prog_full   <= (count_nxt >= CW'(PROG_FULL_THRESH));
      prog_empty  <= (count_nxt <= CW'(PROG_EMPTY_THRESH));
      data_count  <= count_nxt;
      wr_rst_busy <= (state_nxt == ST_BUSY);
      rd_rst_busy <= (state_nxt == ST_BUSY);
`ifdef FIFO_ERR_FLAGS_EN
      overflow    <= overflow_nxt;
      underflow   <= underflow_nxt;
`endif
    end
  end

  // Storage array is not reset; queued data is discarded via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: standard-read instance plus an FWFT instance.
module tb_sync_fifo_param;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  logic [W-1:0] din, dout;
  logic wr_en, rd_en, full, empty, prog_full, prog_empty, wr_rst_busy, rd_rst_busy;
  logic [4:0] data_count;
  logic [W-1:0] f_din, f_dout;
  logic f_wr_en, f_rd_en, f_full, f_empty, f_prog_full, f_prog_empty, f_wr_rst_busy, f_rd_rst_busy;
  logic [4:0] f_data_count;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow, underflow, f_overflow, f_underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_param #(.WIDTH(W), .DEPTH(16), .FWFT(0), .PROG_FULL_THRESH(12),
                    .PROG_EMPTY_THRESH(2), .RST_BUSY_CYCLES(4)) dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
    .full(full), .empty(empty), .prog_full(prog_full), .prog_empty(prog_empty),
    .data_count(data_count), .wr_rst_busy(wr_rst_busy), .rd_rst_busy(rd_rst_busy)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(16), .FWFT(1), .PROG_FULL_THRESH(12),
                    .PROG_EMPTY_THRESH(2), .RST_BUSY_CYCLES(4)) dut_fwft (
    .clk(clk), .srst(srst), .din(f_din), .wr_en(f_wr_en), .rd_en(f_rd_en), .dout(f_dout),
    .full(f_full), .empty(f_empty), .prog_full(f_prog_full), .prog_empty(f_prog_empty),
    .data_count(f_data_count), .wr_rst_busy(f_wr_rst_busy), .rd_rst_busy(f_rd_rst_busy)
`ifdef FIFO_ERR_FLAGS_EN
    , .overflow(f_overflow), .underflow(f_underflow)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    srst = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    srst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
    f_din = '0; f_wr_en = 1'b0; f_rd_en = 1'b0;
    repeat (2) tick();

    // Reset state, with a write held during reset and busy.
    check("rst_full", full, 1);
    check("rst_empty", empty, 1);
    check("rst_prog_full", prog_full, 0);
    check("rst_prog_empty", prog_empty, 1);
    check("rst_count", data_count, 0);
    check("rst_dout", dout, 0);
    check("rst_wbusy", wr_rst_busy, 1);
    check("rst_rbusy", rd_rst_busy, 1);
    din = 32'hDEAD; wr_en = 1'b1;
    srst = 1'b0;
    repeat (3) tick();
    check("busy_e3_wbusy", wr_rst_busy, 1);
    check("busy_e3_full", full, 1);
    tick();
    wr_en = 1'b0;
    check("busy_e4_wbusy", wr_rst_busy, 0);
    check("busy_e4_rbusy", rd_rst_busy, 0);
    check("busy_e4_full", full, 0);
    check("busy_e4_empty", empty, 1);
    check("busy_e4_count", data_count, 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("busy_no_ovf", overflow, 0);
`endif

    // Fill 16 words.
    for (int i = 0; i < 16; i++) begin
      din = 32'h100 + 32'(i); wr_en = 1'b1;
      tick();
      check($sformatf("fill_pfull_%0d", i + 1), prog_full, (i + 1 >= 12) ? 1 : 0);
      check($sformatf("fill_full_%0d", i + 1), full, (i + 1 == 16) ? 1 : 0);
    end
    check("fill_count", data_count, 16);
    din = 32'h1FF;
    tick();
    check("ovf_count", data_count, 16);
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_pulse", overflow, 1);
`endif
    wr_en = 1'b0;
    tick();
`ifdef FIFO_ERR_FLAGS_EN
    check("ovf_clear", overflow, 0);
`endif

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      check($sformatf("drain_%0d", i), dout, 32'h100 + 32'(i));
    end
    check("drain_empty", empty, 1);
    check("drain_pempty", prog_empty, 1);
    tick();
    rd_en = 1'b0;
    check("udf_count", data_count, 0);
    check("udf_dout_hold", dout, 32'h10F);
`ifdef FIFO_ERR_FLAGS_EN
    check("udf_pulse", underflow, 1);
`endif

    // Write+read at empty: only the write takes effect.
    din = 32'h55; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("we_count", data_count, 1);
    check("we_dout_hold", dout, 32'h10F);
    check("we_empty", empty, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("we_read", dout, 32'h55);
    check("we_empty_after", empty, 1);

    // Streaming across pointer wrap at count 3.
    for (int i = 0; i < 3; i++) begin
      din = 32'h200 + 32'(i); wr_en = 1'b1;
      tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = 32'h203 + 32'(i);
      tick();
      check($sformatf("wrap_dout_%0d", i), dout, 32'h200 + 32'(i));
    end
    wr_en = 1'b0;
    check("wrap_count", data_count, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("wrap_tail_%0d", i), dout, 32'h228 + 32'(i));
    end
    rd_en = 1'b0;
    check("wrap_empty", empty, 1);

    // Write+read at full: write dropped, read accepted.
    for (int i = 0; i < 16; i++) begin
      din = 32'h300 + 32'(i); wr_en = 1'b1;
      tick();
    end
    din = 32'h3FF; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("fb_read", dout, 32'h300);
    check("fb_count", data_count, 15);
    check("fb_full", full, 0);
`ifdef FIFO_ERR_FLAGS_EN
    check("fb_ovf", overflow, 1);
`endif
    rd_en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      check($sformatf("fb_drain_%0d", i), dout, 32'h300 + 32'(i));
    end
    rd_en = 1'b0;
    check("fb_empty", empty, 1);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 9; i++) begin
      din = 32'h400 + 32'(i); wr_en = 1'b1;
      tick();
    end
    check("ar_count9", data_count, 9);
    din = 32'h4AA;
    #2 srst = 1'b1;
    #1;
    check("ar_count", data_count, 0);
    check("ar_empty", empty, 1);
    check("ar_full", full, 1);
    check("ar_busy", wr_rst_busy, 1);
    wr_en = 1'b0;
    tick();
    release_reset();
    check("ar_rel_full", full, 0);
    din = 32'h777; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("ar_post_data", dout, 32'h777);
    check("ar_post_empty", empty, 1);

    // FWFT instance: head visible without rd_en.
    check("fw_idle_empty", f_empty, 1);
    f_din = 32'hCAFE; f_wr_en = 1'b1;
    tick();
    f_din = 32'hBEEF;
    check("fw_head", f_dout, 32'hCAFE);
    check("fw_nonempty", f_empty, 0);
    tick();
    f_wr_en = 1'b0;
    check("fw_head_hold", f_dout, 32'hCAFE);
    f_rd_en = 1'b1;
    tick();
    check("fw_pop1", f_dout, 32'hBEEF);
    check("fw_pop1_empty", f_empty, 0);
    tick();
    f_rd_en = 1'b0;
    check("fw_pop2_empty", f_empty, 1);
    check("fw_pop2_count", f_data_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
